vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
- Produces the raster position and sync timing that feed every screen drawer (row, column, display_enable) and the VGA connector (hsync, vsync).
- This is the producer side of the row/column/display_enable interface that the drawers and the VGA interface consume.
- Runs on vga_clock. An optional pixel_enable qualifier lets it run from a faster clock.
- Default timing: 640x480 at 60 Hz (800 x 525 total, 25.175 MHz nominal pixel rate).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 0, 0 = hsync/vsync active-low, 1 = active-high

Ports:
- vga_clock  in  1  pixel/system clock
- reset  in  1  synchronous, active-high reset
- pixel_enable  in  1  advance one pixel when high; tie to 1 for a native pixel clock
- column  out  int (32)  horizontal count 0..H_TOTAL-1
- row  out  int (32)  vertical count 0..V_TOTAL-1
- display_enable  out  1  high when column < H_ACTIVE and row < V_ACTIVE
- hsync  out  1  horizontal sync, polarity set by SYNC_ACTIVE_HIGH
- vsync  out  1  vertical sync, polarity set by SYNC_ACTIVE_HIGH
- line_start  out  1  one-pixel pulse when column == 0
- frame_start  out  1  one-pixel pulse when column == 0 and row == 0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Internal counters: h_cnt and v_cnt, both reset to 0.
- Counter update, on each vga_clock edge with pixel_enable=1:
  - if h_cnt == H_TOTAL-1: h_cnt <= 0, and v_cnt <= (v_cnt == V_TOTAL-1) ? 0 : v_cnt+1
  - else: h_cnt <= h_cnt+1
- Wrap-around: both counters wrap simultaneously at (799,524) -> (0,0).
- All outputs are registered.
  - On each enabled edge, the output registers load the decode of the pre-increment (h_cnt, v_cnt).
  - Outputs therefore describe the pixel whose counter value was current one enabled cycle earlier.
  - All outputs are mutually aligned, with no skew between them.
- Sync windows:
  - hsync asserted for column in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] = [656,751]
  - vsync asserted for row in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] = [490,491]
  - "Asserted" is the level given by SYNC_ACTIVE_HIGH.
- row/column are raw counts and are not clamped in blanking. Consumers qualify them with display_enable.
- pixel_enable=0: counters and all output registers hold. Pulses stretch for the whole held interval; consumers sample them with pixel_enable.
- Reset:
  - While reset=1: h_cnt=v_cnt=0, column=row=0, display_enable=0, line_start=frame_start=0, hsync=vsync at the inactive level.
  - Reset has priority over pixel_enable.
  - Reset mid-frame abandons the frame immediately; no partial sync pulse is completed.
- First enabled edge after reset release: outputs show column=0, row=0, display_enable=1, line_start=1, frame_start=1.
- Frame period: exactly H_TOTAL*V_TOTAL = 420000 enabled cycles between frame_start pulses.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN.
- With the macro defined:
  - Adds output frame_count [15:0], reset 0.
  - Increments (wrapping 65535 -> 0) on the same enabled edge that registers frame_start=1, excluding the first frame_start after reset.
  - Drawers use it for animation and blinking.
- Without the macro: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (640x480@60 values above)
  - a typedef struct for the porch/sync/active set
  - H_TOTAL/V_TOTAL helper functions
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical).
  - Parameters: ACTIVE, FRONT, SYNC, BACK.
  - Inputs: clock, reset, advance.
  - Outputs: count, at_last, active, sync_window.
  - Vertical instance advance = pixel_enable && horizontal at_last.

Test Plan:
- Reset, then pixel_enable=1 for 1 cycle -> column=0, row=0, display_enable=1, frame_start=1, hsync=vsync=1 (defaults).
- Run 800 enabled cycles -> column sequence 0..799 then 0.
  - display_enable high for columns 0..639.
  - hsync low exactly for columns 656..751 (96 cycles).
  - line_start pulses at column 0.
  - row increments to 1 on the wrap.
- Run a full frame -> frame_start pulses exactly 420000 cycles apart.
  - vsync low for exactly 1600 cycles (rows 490..491).
  - display_enable low throughout rows 480..524.
- Toggle pixel_enable at 50% (divide-by-2) -> every output holds 2 clocks per pixel; frame period 840000 clocks; no glitch on hsync.
- Assert reset for 1 cycle at row=300, column=400 -> next cycle shows inactive outputs; first enabled cycle after release shows (0,0) with frame_start=1.
- With VGA_FRAME_COUNTER_EN, run 3 frames after reset -> frame_count reads 0, 1, 2 at successive frame_start pulses. Preload the counter to 65535 -> next frame reads 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 raster timing, the per-axis timing record
//               and helpers that derive the total count of an axis.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // 640x480 at 60 Hz, 25.175 MHz nominal pixel rate
    localparam int C_H_ACTIVE = 640;
    localparam int C_H_FRONT  = 16;
    localparam int C_H_SYNC   = 96;
    localparam int C_H_BACK   = 48;
    localparam int C_V_ACTIVE = 480;
    localparam int C_V_FRONT  = 10;
    localparam int C_V_SYNC   = 2;
    localparam int C_V_BACK   = 33;

    // Active/porch/sync set describing one raster axis
    typedef struct packed {
        int active;
        int front;
        int sync;
        int back;
    } axis_timing_t;

    // Total pixels per line, blanking included
    function automatic int h_total(input axis_timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

    // Total lines per frame, blanking included
    function automatic int v_total(input axis_timing_t t);
        return t.active + t.front + t.sync + t.back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : Wrapping position counter for one raster axis with decode of
//               the last position, the visible region and the sync window.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    output logic [31:0] count,
    output logic        at_last,
    output logic        active,
    output logic        sync_window
);
    import vga_timing_pkg::*;

    localparam axis_timing_t c_timing     = '{ACTIVE, FRONT, SYNC, BACK};
    localparam int           c_total      = h_total(c_timing);
    localparam logic [31:0]  c_last       = 32'(c_total - 1);
    localparam logic [31:0]  c_active     = 32'(ACTIVE);
    localparam logic [31:0]  c_sync_first = 32'(ACTIVE + FRONT);
    localparam logic [31:0]  c_sync_last  = 32'(ACTIVE + FRONT + SYNC - 1);

    logic [31:0] r_count;

    // Step the position on each advance, wrapping after the last position
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (advance) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 32'd1;
        end
    end

    assign count       = r_count;
    assign at_last     = (r_count == c_last);
    assign active      = (r_count < c_active);
    assign sync_window = (r_count >= c_sync_first) && (r_count <= c_sync_last);

endmodule
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator
// Description : Raster position and sync generator. Outputs are registered
//               decodes of the counter state one enabled pixel earlier, so
//               every output is mutually aligned. Build option
//               VGA_FRAME_COUNTER_EN adds a 16-bit frame counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
    parameter int H_ACTIVE         = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_ACTIVE         = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        pixel_enable,
    output logic [31:0] column,
    output logic [31:0] row,
    output logic        display_enable,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [15:0] frame_count
`endif
);
    import vga_timing_pkg::*;

    localparam logic c_sync_on  = SYNC_ACTIVE_HIGH;
    localparam logic c_sync_off = ~SYNC_ACTIVE_HIGH;

    logic [31:0] w_h_count;
    logic [31:0] w_v_count;
    logic        w_h_at_last;
    logic        w_v_at_last;
    logic        w_h_active;
    logic        w_v_active;
    logic        w_h_sync;
    logic        w_v_sync;
    logic        w_v_advance;
    logic        w_frame_origin;
    logic        w_unused;

    logic [31:0] r_column;
    logic [31:0] r_row;
    logic        r_display_enable;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_line_start;
    logic        r_frame_start;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clock       (vga_clock),
        .reset       (reset),
        .advance     (pixel_enable),
        .count       (w_h_count),
        .at_last     (w_h_at_last),
        .active      (w_h_active),
        .sync_window (w_h_sync)
    );

    // Lines advance only when the pixel counter wraps
    assign w_v_advance = pixel_enable && w_h_at_last;

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clock       (vga_clock),
        .reset       (reset),
        .advance     (w_v_advance),
        .count       (w_v_count),
        .at_last     (w_v_at_last),
        .active      (w_v_active),
        .sync_window (w_v_sync)
    );

    // The vertical wrap needs no separate handling; its last-line flag is spare
    assign w_unused       = w_v_at_last;
    assign w_frame_origin = (w_h_count == 32'd0) && (w_v_count == 32'd0);

    // Register the decode of the current counters; hold everything when idle
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_column         <= '0;
            r_row            <= '0;
            r_display_enable <= 1'b0;
            r_hsync          <= c_sync_off;
            r_vsync          <= c_sync_off;
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
        end else if (pixel_enable) begin
            r_column         <= w_h_count;
            r_row            <= w_v_count;
            r_display_enable <= w_h_active && w_v_active;
            r_hsync          <= w_h_sync ? c_sync_on : c_sync_off;
            r_vsync          <= w_v_sync ? c_sync_on : c_sync_off;
            r_line_start     <= (w_h_count == 32'd0);
            r_frame_start    <= w_frame_origin;
        end
    end

    assign column         = r_column;
    assign row            = r_row;
    assign display_enable = r_display_enable;
    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] r_frame_count;
    logic        r_first_frame_seen;

    // Count frame starts after the first one, in step with frame_start
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_frame_count      <= '0;
            r_first_frame_seen <= 1'b0;
        end else if (pixel_enable && w_frame_origin) begin
            r_first_frame_seen <= 1'b1;
            if (r_first_frame_seen) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_generator
// Description : Self-checking bench: a default 640x480 instance for reset and
//               first-line timing, plus a tiny-raster instance (active-high
//               sync) for whole-frame, divide-by-2 and mid-frame reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_generator;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hi;
    } tim_t;

    typedef struct {
        bit rst; bit pe;
        int col; int row;
        bit de; bit hs; bit vs; bit ls; bit fs;
    } vec_t;

    localparam tim_t T_D = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    localparam tim_t T_S = '{10, 2, 3, 5, 6, 2, 2, 3, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        pixel_enable;
    logic [31:0] d_col, d_row, s_col, s_row;
    logic        d_de, d_hs, d_vs, d_ls, d_fs;
    logic        s_de, s_hs, s_vs, s_ls, s_fs;
`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] d_fc, s_fc;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    vga_timing_generator dut (
        .vga_clock      (clk),
        .reset          (reset),
        .pixel_enable   (pixel_enable),
        .column         (d_col),
        .row            (d_row),
        .display_enable (d_de),
        .hsync          (d_hs),
        .vsync          (d_vs),
        .line_start     (d_ls),
        .frame_start    (d_fs)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_count    (d_fc)
`endif
    );

    vga_timing_generator #(
        .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
        .V_ACTIVE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE_HIGH(1'b1)
    ) dut_s (
        .vga_clock      (clk),
        .reset          (reset),
        .pixel_enable   (pixel_enable),
        .column         (s_col),
        .row            (s_row),
        .display_enable (s_de),
        .hsync          (s_hs),
        .vsync          (s_vs),
        .line_start     (s_ls),
        .frame_start    (s_fs)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_count    (s_fc)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input bit r, input bit e);
        reset        = r;
        pixel_enable = e;
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for pixel index p counted from the frame origin
    task automatic check_pix(input string tag, input tim_t t, input int p,
                             input logic [31:0] col, input logic [31:0] row,
                             input logic de, input logic hs, input logic vs,
                             input logic ls, input logic fs);
        int ht, vt, ec, er;
        logic ehs, evs;
        ht  = t.ha + t.hf + t.hs + t.hb;
        vt  = t.va + t.vf + t.vs + t.vb;
        ec  = p % ht;
        er  = (p / ht) % vt;
        ehs = (ec >= t.ha + t.hf && ec < t.ha + t.hf + t.hs) ? t.hi : !t.hi;
        evs = (er >= t.va + t.vf && er < t.va + t.vf + t.vs) ? t.hi : !t.hi;
        chk({tag, ".column"}, col, ec);
        chk({tag, ".row"}, row, er);
        chk({tag, ".display_enable"}, {31'd0, de}, {31'd0, (ec < t.ha) && (er < t.va)});
        chk({tag, ".hsync"}, {31'd0, hs}, {31'd0, ehs});
        chk({tag, ".vsync"}, {31'd0, vs}, {31'd0, evs});
        chk({tag, ".line_start"}, {31'd0, ls}, {31'd0, ec == 0});
        chk({tag, ".frame_start"}, {31'd0, fs}, {31'd0, ec == 0 && er == 0});
    endtask

    task automatic check_rst(input string tag, input bit hi,
                             input logic [31:0] col, input logic [31:0] row,
                             input logic de, input logic hs, input logic vs,
                             input logic ls, input logic fs);
        chk({tag, ".column"}, col, 0);
        chk({tag, ".row"}, row, 0);
        chk({tag, ".display_enable"}, {31'd0, de}, 0);
        chk({tag, ".hsync"}, {31'd0, hs}, {31'd0, !hi});
        chk({tag, ".vsync"}, {31'd0, vs}, {31'd0, !hi});
        chk({tag, ".line_start"}, {31'd0, ls}, 0);
        chk({tag, ".frame_start"}, {31'd0, fs}, 0);
    endtask

    initial begin
        vec_t vecs [9];
        int   p, hs_low, de_high, ls_cnt, vs_cnt, fs_cnt;
        int   fs_at [4];
        int   rise_at [4];
        int   rises, hs_rises;
        logic prev_fs, prev_hs;

        // Default-timing instance: reset, hold, first pixels, reset priority
        vecs[0] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[2] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[3] = '{0, 1, 0, 0, 1, 1, 1, 1, 1};
        vecs[4] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
        vecs[5] = '{0, 1, 1, 0, 1, 1, 1, 0, 0};
        vecs[6] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[7] = '{0, 1, 0, 0, 1, 1, 1, 1, 1};
        vecs[8] = '{0, 1, 1, 0, 1, 1, 1, 0, 0};

        for (int i = 0; i < 9; i++) begin
            tick(vecs[i].rst, vecs[i].pe);
            chk($sformatf("vec%0d.column", i), d_col, vecs[i].col);
            chk($sformatf("vec%0d.row", i), d_row, vecs[i].row);
            chk($sformatf("vec%0d.display_enable", i), {31'd0, d_de}, {31'd0, vecs[i].de});
            chk($sformatf("vec%0d.hsync", i), {31'd0, d_hs}, {31'd0, vecs[i].hs});
            chk($sformatf("vec%0d.vsync", i), {31'd0, d_vs}, {31'd0, vecs[i].vs});
            chk($sformatf("vec%0d.line_start", i), {31'd0, d_ls}, {31'd0, vecs[i].ls});
            chk($sformatf("vec%0d.frame_start", i), {31'd0, d_fs}, {31'd0, vecs[i].fs});
        end

        // Rest of the first line and the wrap into line 1
        hs_low  = 0;
        de_high = 0;
        ls_cnt  = 0;
        for (p = 2; p <= 802; p++) begin
            tick(0, 1);
            check_pix("line", T_D, p, d_col, d_row, d_de, d_hs, d_vs, d_ls, d_fs);
            if (p < 800 && !d_hs) hs_low++;
            if (p < 800 && d_de) de_high++;
            if (d_ls) ls_cnt++;
        end
        chk("line.hsync_low_cycles", hs_low, 96);
        chk("line.de_high_cycles", de_high, 638);
        chk("line.line_start_count", ls_cnt, 1);

        // Tiny raster: two full frames at full rate
        tick(1, 1);
        check_rst("s_reset", 1'b1, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs);
        vs_cnt = 0;
        fs_cnt = 0;
        de_high = 0;
        for (p = 0; p < 2 * 260 + 5; p++) begin
            tick(0, 1);
            check_pix("frame", T_S, p, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs);
            if (p < 260 && s_vs) vs_cnt++;
            if (p < 260 && s_de) de_high++;
            if (s_fs && fs_cnt < 4) begin
                fs_at[fs_cnt] = p;
                fs_cnt++;
            end
        end
        chk("frame.vsync_cycles", vs_cnt, 40);
        chk("frame.de_cycles", de_high, 60);
        chk("frame.fs_count", fs_cnt, 3);
        if (fs_cnt >= 3) begin
            chk("frame.period0", fs_at[1] - fs_at[0], 260);
            chk("frame.period1", fs_at[2] - fs_at[1], 260);
        end

        // Divide-by-2 enable: outputs hold two clocks per pixel
        tick(1, 1);
        p        = -1;
        rises    = 0;
        hs_rises = 0;
        prev_fs  = 1'b0;
        prev_hs  = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            tick(0, (k % 2) == 0);
            if ((k % 2) == 0) p++;
            check_pix("div2", T_S, p, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs);
            if (s_fs && !prev_fs && rises < 4) begin
                rise_at[rises] = k;
                rises++;
            end
            if (rises == 1 && s_hs && !prev_hs) hs_rises++;
            prev_fs = s_fs;
            prev_hs = s_hs;
        end
        chk("div2.fs_rises", rises, 3);
        if (rises >= 2) chk("div2.period_clocks", rise_at[1] - rise_at[0], 520);
        chk("div2.hsync_pulses_per_frame", hs_rises, 13);

        // Reset in the middle of both sync pulses (row 8, column 13)
        tick(1, 1);
        for (p = 0; p <= 173; p++) tick(0, 1);
        check_pix("mid.before", T_S, 173, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs);
        tick(1, 1);
        check_rst("mid.reset", 1'b1, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs);
        tick(0, 0);
        check_rst("mid.hold", 1'b1, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs);
        tick(0, 1);
        check_pix("mid.first", T_S, 0, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs);
        tick(0, 1);
        check_pix("mid.second", T_S, 1, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs);

`ifdef VGA_FRAME_COUNTER_EN
        // Frame counter reads 0,1,2,3 at successive frame starts
        tick(1, 1);
        chk("fc.reset", {16'd0, s_fc}, 0);
        chk("fc.reset_default", {16'd0, d_fc}, 0);
        fs_cnt = 0;
        for (p = 0; p <= 3 * 260; p++) begin
            tick(0, 1);
            if (s_fs) begin
                chk($sformatf("fc.frame%0d", fs_cnt), {16'd0, s_fc}, fs_cnt);
                fs_cnt++;
            end
        end
        chk("fc.pulses", fs_cnt, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
